fsmc_sample_fifo_regs: RTL
==========================

// Module: fsmc_sample_fifo_regs
// PURPOSE
//  Register bank plus sample FIFO directly downstream of fsmc_interface. Decodes its
//  cs/wr_en/rd_en strobes, holds control/threshold registers, buffers ADC samples in a
//  first-word-fall-through FIFO and returns read data on rd_data for the MCU FSMC bus.
//  Reading the DATA register pops one sample. irq flags the MCU when the fill level
//  reaches a programmable threshold.
// PARAMETERS
//  DATA_W   16   sample and register data width
//  DEPTH    512  FIFO depth in samples; power of two, >= 4
//  CS_W     4    width of encoded register index from fsmc_interface
// PORTS
//  clk           in   1       system clock, single domain
//  reset         in   1       asynchronous, active-high reset
//  cs            in   CS_W    encoded register index, valid while rd_en/wr_en high
//  wr_en         in   1       1-cycle write strobe from fsmc_interface
//  rd_en         in   1       1-cycle read-complete strobe (end of NOE low)
//  wr_data       in   DATA_W  MCU write data
//  rd_data       out  DATA_W  read data, registered mux of cs
//  sample_valid  in   1       1-cycle ADC sample strobe
//  sample_data   in   DATA_W  ADC sample
//  irq           out  1       level-high interrupt: capture enabled && level >= THRESH
// BEHAVIOUR
//  Interface: one clock (clk); asynchronous, active-high reset (reset).
//  Reset: rd_data=0, irq=0, CTRL=0, THRESH=DEPTH/2, FIFO empty, sticky flags 0.
//  Register map (cs):
//   0 CTRL   RW  [0] capture_en, [1] clear (write-1, self-clears next cycle, reads 0)
//   1 STATUS RO  [0] empty, [1] full, [2] overflow, [3] underflow; clear-on-read of [3:2]
//   2 DATA   RO  FIFO head (FWFT); rd_en pops; 0x0000 when empty
//   3 LEVEL  RO  current fill count, zero-extended
//   4 THRESH RW  irq threshold, low clog2(DEPTH)+1 bits significant
//   others: reads 0x0000, writes ignored
//  rd_data: registered every cycle from cs -> 1-cycle latency after cs changes;
//   must be stable before rd_en pulse (FSMC data phase >> 1 cycle).
//  Push: sample_valid && capture_en && !full. Push while full -> sample dropped,
//   overflow=1. sample_valid ignored when capture_en=0 (no flag).
//  Pop: rd_en && cs==2 && !empty. Pop on empty -> no change, underflow=1.
//  Simultaneous push+pop: level unchanged, both take effect (full+pop+push legal).
//  Clear (CTRL[1] write): pointers/level to 0 next cycle; overrides push/pop same cycle;
//   does not clear sticky flags.
//  STATUS clear-on-read happens at rd_en; a flag event in the same cycle wins (stays 1).
//  wr_en to RO register: ignored. wr_en and rd_en same cycle: both honoured.
//  Pointers wrap modulo DEPTH; level counter clog2(DEPTH)+1 bits, never exceeds DEPTH.
//  irq registered, 1-cycle after level/THRESH/capture_en change; THRESH=0 -> irq whenever
//   capture_en=1.
//  Reset mid-operation: all state to reset values immediately; FIFO content discarded.
// STRUCTURE
//  fsmc_pkg: register index localparams (REG_CTRL..REG_THRESH), STATUS/CTRL bit positions.
//  Sub-module sync_fifo_fwft (DATA_W, DEPTH): inferred RAM, wr/rd pointers, level,
//   full/empty, sync clear. Top holds decode, registers, sticky flags, rd_data mux, irq.
// TESTING
//  1 reset -> rd_data=0, irq=0; read cs=4 returns 0x0100 (DEPTH=512), cs=1 returns 0x0001.
//  2 CTRL=1, push 0x0F0F,0x2321; read cs=3 -> 2; two DATA reads -> 0x0F0F then 0x2321, empty=1.
//  3 capture on, push 513 samples -> full=1, overflow=1, LEVEL=512; STATUS read clears
//    overflow, next STATUS read full=1 overflow=0.
//  4 DATA read on empty -> 0x0000, underflow=1; level stays 0.
//  5 THRESH=4: 3 pushes irq=0, 4th push -> irq=1 next cycle; one pop -> irq=0.
//  6 level=10, write CTRL=3 with simultaneous sample_valid -> LEVEL=0, CTRL reads 1;
//    assert reset mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fsmc_sample_fifo_regs_pkg.sv
// rtl/fsmc_sample_fifo_regs_pkg.sv - register indices and bit positions for the FSMC sample FIFO bank
package fsmc_sample_fifo_regs_pkg;

   localparam int unsigned REG_CTRL   = 0;
   localparam int unsigned REG_STATUS = 1;
   localparam int unsigned REG_DATA   = 2;
   localparam int unsigned REG_LEVEL  = 3;
   localparam int unsigned REG_THRESH = 4;

   localparam int unsigned CTRL_CAPTURE_BIT = 0;
   localparam int unsigned CTRL_CLEAR_BIT   = 1;

   localparam int unsigned ST_EMPTY     = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_OVERFLOW  = 2;
   localparam int unsigned ST_UNDERFLOW = 3;
   localparam int unsigned ST_W         = 4;

   // Level counter needs one extra bit so that "full" (== DEPTH) is representable.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fsmc_sample_fifo_regs_fifo.sv
// rtl/fsmc_sample_fifo_regs_fifo.sv - first-word-fall-through sample FIFO with synchronous clear
module fsmc_sample_fifo_regs_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 512,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] head_o,
   output logic [LW-1:0]     level_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(push_i) - LW'(pop_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset; validity is tracked purely by the pointers and level.
   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;
   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);

endmodule

// File: rtl/fsmc_sample_fifo_regs.sv
// rtl/fsmc_sample_fifo_regs.sv - FSMC register decode, sticky flags, read mux and irq around the sample FIFO
module fsmc_sample_fifo_regs
   import fsmc_sample_fifo_regs_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 512,
   parameter int unsigned CS_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CS_W-1:0]   cs,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   output logic              irq
);

   localparam int unsigned LW = level_width(DEPTH);

   logic              sel_ctrl, sel_status, sel_data, sel_thresh;
   logic              data_rd, ovf_evt, udf_evt;
   logic              fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic [LW-1:0]     fifo_level;
   logic [ST_W-1:0]   status;

   logic              capture_q, capture_d;
   logic [LW-1:0]     thresh_q, thresh_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              irq_q, irq_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              unused_wr_data;

   assign sel_ctrl   = (cs == CS_W'(REG_CTRL));
   assign sel_status = (cs == CS_W'(REG_STATUS));
   assign sel_data   = (cs == CS_W'(REG_DATA));
   assign sel_thresh = (cs == CS_W'(REG_THRESH));
   assign unused_wr_data = ^wr_data[DATA_W-1:LW];

   // A full FIFO still accepts a sample when a pop frees the slot in the same cycle.
   always_comb begin
      data_rd    = rd_en && sel_data;
      fifo_clear = wr_en && sel_ctrl && wr_data[CTRL_CLEAR_BIT];
      fifo_pop   = data_rd && !fifo_empty;
      fifo_push  = sample_valid && capture_q && (!fifo_full || fifo_pop);
      ovf_evt    = sample_valid && capture_q && fifo_full && !fifo_pop;
      udf_evt    = data_rd && fifo_empty;
   end

   fsmc_sample_fifo_regs_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .clear_i (fifo_clear),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (sample_data),
      .head_o  (fifo_head),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      capture_d = capture_q;
      thresh_d  = thresh_q;
      if (wr_en && sel_ctrl)   capture_d = wr_data[CTRL_CAPTURE_BIT];
      if (wr_en && sel_thresh) thresh_d  = wr_data[LW-1:0];

      // A new flag event in the same cycle as the STATUS read keeps the flag set.
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (rd_en && sel_status) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (ovf_evt) ovf_d = 1'b1;
      if (udf_evt) udf_d = 1'b1;

      irq_d = capture_q && (fifo_level >= thresh_q);

      status               = '0;
      status[ST_EMPTY]     = fifo_empty;
      status[ST_FULL]      = fifo_full;
      status[ST_OVERFLOW]  = ovf_q;
      status[ST_UNDERFLOW] = udf_q;

      rd_data_d = '0;
      case (cs)
         CS_W'(REG_CTRL):   rd_data_d = DATA_W'(capture_q);
         CS_W'(REG_STATUS): rd_data_d = DATA_W'(status);
         CS_W'(REG_DATA):   rd_data_d = fifo_empty ? '0 : fifo_head;
         CS_W'(REG_LEVEL):  rd_data_d = DATA_W'(fifo_level);
         CS_W'(REG_THRESH): rd_data_d = DATA_W'(thresh_q);
         default:           rd_data_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         capture_q <= 1'b0;
         thresh_q  <= LW'(DEPTH / 2);
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         irq_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         capture_q <= capture_d;
         thresh_q  <= thresh_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         irq_q     <= irq_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
   assign irq     = irq_q;

endmodule
